instr_align_queue: RTL and testbench
====================================

// Module: instr_align_queue
// PURPOSE
//  Parametrised halfword instruction queue between fetch and decode, replacing the
//  single-register fetch->decode hand-off. Buffers aligned 32-bit fetch words and
//  extracts 16-bit (RVC) or 32-bit instructions, including ones straddling two words.
//  Presents one instruction per cycle with pc/npc/exception tags. Decouples fetch from
//  decode stalls and drops all state on pipeline flush.
// PARAMETERS
//  DEPTH   8   queue capacity in halfwords; power of two, >=4
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous reset, active-low
//  flush       in   1   discard queue contents (jump/exception/mret redirect)
//  flush_pc    in   32  redirect target; bit 1 selects starting halfword
//  f_valid     in   1   fetch word available
//  f_ready     out  1   queue accepts fetch word this cycle
//  f_addr      in   32  fetch word address, [1:0]==0
//  f_data      in   32  fetch word, little-endian halfwords
//  f_error     in   1   fetch access fault for this word
//  d_valid     out  1   instruction available to decode
//  d_ready     in   1   decode consumes instruction (low when decode stalls)
//  d_pc        out  32  instruction pc
//  d_npc       out  32  d_pc+2 (16-bit) or d_pc+4 (32-bit)
//  d_instr     out  32  instruction; 16-bit form zero-extended in [31:16]
//  d_exception out  1   fetch fault on any halfword of this instruction
//  d_etval     out  32  faulting halfword address when d_exception
// BEHAVIOUR
//  - Storage: DEPTH entries {data[15:0], pc[31:1], err}; rd/wr pointers wrap modulo DEPTH;
//    count 0..DEPTH ($clog2(DEPTH)+1 bits). Pointer wrap transparent to outputs.
//  - Reset (rst=0, async): count=0, pointers=0, skip=0; d_valid=0, f_ready=1,
//    d_pc/d_npc/d_instr/d_etval=0, d_exception=0.
//  - Push: f_ready = (DEPTH-count >= 2) & ~flush. On f_valid&f_ready write halfword
//    {f_data[15:0],f_addr} then {f_data[31:16],f_addr+2}, err=f_error on both; if skip=1
//    write only the upper halfword and clear skip.
//  - Head decode (combinational from storage, no extra register): head halfword h0,
//    next h1. If h0[1:0]!=2'b11: 16-bit, needs count>=1. Else 32-bit, needs count>=2,
//    d_instr={h1,h0}. Exception: 32-bit with h0.err=1 is issued with count>=1 (h1 not
//    needed); d_etval = pc of first faulting halfword, else 0.
//  - d_valid = instruction complete & ~flush. Pop 1 (16-bit) or 2 (32-bit, or 1 if
//    issued on h0.err alone) halfwords on d_valid&d_ready.
//  - Latency: word accepted at edge N -> d_valid earliest in cycle after N.
//    Throughput one instruction/cycle.
//  - Push and pop in same cycle allowed; count += pushed - popped. Full: f_ready=0;
//    pop same cycle does not raise f_ready (no combinational d_ready->f_ready path).
//  - Empty or incomplete 32-bit head: d_valid=0; outputs hold last head values.
//  - Flush (highest priority): next edge count=0, pointers=0, skip=flush_pc[1]; push and
//    pop in the flush cycle are discarded; d_valid=0, f_ready=0 in flush cycle.
//  - Reset mid-operation: state returns to reset values immediately, any queued
//    instructions lost.
// CONFIGURATION
//  INSTR_ALIGN_RVC_EN defined: 16/32-bit extraction as above, flush_pc[1] honoured.
//  Not defined: every instruction 32-bit, always {h1,h0}, needs count>=2 (or h0.err),
//    d_npc=d_pc+4, skip forced 0, flush_pc[1] ignored; head[1:0]!=2'b11 passed
//    unchanged for decoder to flag illegal.
// TESTING
//  1 words 0x00A00093@0x0, 0x00B00113@0x4, d_ready=1 -> two 32-bit instrs, pc 0x0/0x4, npc 0x4/0x8
//  2 (RVC_EN) word 0x00934505@0x100, word 0x00000013@0x104 -> 0x4505 pc 0x100 npc 0x102;
//    0x00130093 pc 0x102 npc 0x106; 0x0000 pc 0x106 npc 0x108
//  3 d_ready=0, f_valid=1 with DEPTH=8 -> f_ready low after 4 words, count=8; d_ready=1 drains in order
//  4 flush with flush_pc=0x202 (RVC_EN), then word 0x4501xxxx@0x200 -> first d_pc=0x202, d_instr=0x4501
//  5 word @0x300 f_error=1 -> d_exception=1, d_pc=0x300, d_etval=0x300, no stall on missing h1
//  6 rst low mid-stream with count=5 -> d_valid=0, f_ready=1 same cycle, queue empty after release

Source files
------------

// File: rtl/instr_align_queue.sv
// Halfword instruction queue between fetch and decode: buffers 32-bit fetch words and
// extracts 16/32-bit instructions. Compressed support is enabled by INSTR_ALIGN_RVC_EN.
module instr_align_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_addr,
    input  logic [31:0] f_data,
    input  logic        f_error,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_pc,
    output logic [31:0] d_npc,
    output logic [31:0] d_instr,
    output logic        d_exception,
    output logic [31:0] d_etval
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_data [DEPTH];
    logic [30:0]   r_pc   [DEPTH];
    logic          r_err  [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic          r_skip;

    logic [31:0]   r_hold_pc;
    logic [31:0]   r_hold_npc;
    logic [31:0]   r_hold_instr;
    logic          r_hold_exc;
    logic [31:0]   r_hold_etval;

    logic [AW-1:0] w_rd_nxt;
    logic [AW-1:0] w_wa_hi;
    logic [15:0]   w_h0;
    logic [15:0]   w_h1;
    logic [30:0]   w_pc0;
    logic [30:0]   w_pc1;
    logic          w_e0;
    logic          w_e1;
    logic          w_is32;
    logic          w_cnt_ge1;
    logic          w_cnt_ge2;
    logic          w_complete;
    logic          w_exc;
    logic [31:0]   w_pc;
    logic [31:0]   w_npc;
    logic [31:0]   w_instr;
    logic [31:0]   w_etval;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_push_cnt;
    logic [CW-1:0] w_pop_cnt;
    logic          w_flush_skip;
    logic          w_unused;

    assign w_unused = ^{flush_pc[31:2], flush_pc[0], f_addr[1:0]};

    // Depends only on registered count, so decode readiness never reaches f_ready.
    assign f_ready = (r_count <= CW'(DEPTH - 2)) & ~flush;
    assign w_push  = f_valid & f_ready;

    assign w_rd_nxt  = r_rd_ptr + 1'b1;
    assign w_h0      = r_data[r_rd_ptr];
    assign w_h1      = r_data[w_rd_nxt];
    assign w_pc0     = r_pc[r_rd_ptr];
    assign w_pc1     = r_pc[w_rd_nxt];
    assign w_e0      = r_err[r_rd_ptr];
    assign w_e1      = r_err[w_rd_nxt];
    assign w_cnt_ge1 = (r_count != '0);
    assign w_cnt_ge2 = (r_count >= CW'(2));

`ifdef INSTR_ALIGN_RVC_EN
    assign w_is32       = (w_h0[1:0] == 2'b11);
    assign w_flush_skip = flush_pc[1];
`else
    assign w_is32       = 1'b1;
    assign w_flush_skip = 1'b0;
`endif

    // A faulting first halfword is issued without waiting for its partner.
    assign w_complete = w_is32 ? (w_cnt_ge2 | (w_cnt_ge1 & w_e0)) : w_cnt_ge1;
    assign w_exc      = w_e0 | (w_is32 & w_cnt_ge2 & w_e1);
    assign w_pc       = {w_pc0, 1'b0};
    assign w_npc      = w_pc + (w_is32 ? 32'd4 : 32'd2);
    assign w_instr    = w_is32 ? {w_h1, w_h0} : {16'h0000, w_h0};
    assign w_etval    = w_e0 ? {w_pc0, 1'b0} : (w_exc ? {w_pc1, 1'b0} : 32'd0);

    assign d_valid     = w_complete & ~flush;
    assign d_pc        = w_complete ? w_pc    : r_hold_pc;
    assign d_npc       = w_complete ? w_npc   : r_hold_npc;
    assign d_instr     = w_complete ? w_instr : r_hold_instr;
    assign d_exception = w_complete ? w_exc   : r_hold_exc;
    assign d_etval     = w_complete ? w_etval : r_hold_etval;

    assign w_pop      = d_valid & d_ready;
    assign w_pop_cnt  = !w_pop ? CW'(0) : ((w_is32 & w_cnt_ge2) ? CW'(2) : CW'(1));
    assign w_push_cnt = !w_push ? CW'(0) : (r_skip ? CW'(1) : CW'(2));
    assign w_wa_hi    = r_skip ? r_wr_ptr : (r_wr_ptr + 1'b1);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic [AW-1:0] IDX = AW'(gi);
            always_ff @(posedge clk) begin
                if (w_push) begin
                    if (!r_skip && (r_wr_ptr == IDX)) begin
                        r_data[gi] <= f_data[15:0];
                        r_pc[gi]   <= {f_addr[31:2], 1'b0};
                        r_err[gi]  <= f_error;
                    end else if (w_wa_hi == IDX) begin
                        r_data[gi] <= f_data[31:16];
                        r_pc[gi]   <= {f_addr[31:2], 1'b1};
                        r_err[gi]  <= f_error;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_skip   <= 1'b0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_skip   <= w_flush_skip;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_cnt[AW-1:0];
            r_rd_ptr <= r_rd_ptr + w_pop_cnt[AW-1:0];
            r_count  <= r_count + w_push_cnt - w_pop_cnt;
            if (w_push) begin
                r_skip <= 1'b0;
            end
        end
    end

    // Last complete head, shown while the queue is empty or waiting on a second halfword.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_pc    <= '0;
            r_hold_npc   <= '0;
            r_hold_instr <= '0;
            r_hold_exc   <= 1'b0;
            r_hold_etval <= '0;
        end else if (w_complete) begin
            r_hold_pc    <= w_pc;
            r_hold_npc   <= w_npc;
            r_hold_instr <= w_instr;
            r_hold_exc   <= w_exc;
            r_hold_etval <= w_etval;
        end
    end
endmodule

// File: tb/tb_instr_align_queue.sv
// Directed bench for instr_align_queue (DEPTH=8); RVC-only sequences under INSTR_ALIGN_RVC_EN.
module tb_instr_align_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        f_valid = 1'b0;
    logic        f_ready;
    logic [31:0] f_addr = '0;
    logic [31:0] f_data = '0;
    logic        f_error = 1'b0;
    logic        d_valid;
    logic        d_ready = 1'b0;
    logic [31:0] d_pc, d_npc, d_instr, d_etval;
    logic        d_exception;

    int total = 0;
    int bad   = 0;

    instr_align_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr), .f_data(f_data),
        .f_error(f_error), .d_valid(d_valid), .d_ready(d_ready), .d_pc(d_pc),
        .d_npc(d_npc), .d_instr(d_instr), .d_exception(d_exception), .d_etval(d_etval)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic [31:0] fd;
        logic        fe;
        logic        dr;
        logic        ev;
        logic        efr;
        logic [31:0] epc;
        logic [31:0] enpc;
        logic [31:0] einstr;
        logic        eexc;
        logic [31:0] eetv;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fa, input logic [31:0] fd,
                         input logic fe, input logic dr);
        f_valid = fv; f_addr = fa; f_data = fd; f_error = fe; d_ready = dr;
    endtask

    task automatic chk_instr(input string nm, input logic [31:0] pc, input logic [31:0] npc,
                             input logic [31:0] ins);
        chk({nm, ".valid"}, {31'd0, d_valid}, 32'd1);
        chk({nm, ".pc"}, d_pc, pc);
        chk({nm, ".npc"}, d_npc, npc);
        chk({nm, ".instr"}, d_instr, ins);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h0, 32'h00A00093, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h4, 32'h00B00113, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h4, 32'h00A00093, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4, 32'h8, 32'h00B00113, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h8, 32'h00B00113, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h300, 32'hDEAD0003, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'h8, 32'h00B00113, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h304, 32'hDEAD0003, 1'b1, 32'h300};
        vecs[6] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h300, 32'h304, 32'hDEAD0003, 1'b1, 32'h300};
        vecs[7] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h304, 32'hDEAD0003, 1'b1, 32'h300};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst.f_ready", {31'd0, f_ready}, 32'd1);
        chk("rst.d_pc", d_pc, 32'd0);
        chk("rst.d_npc", d_npc, 32'd0);
        chk("rst.d_instr", d_instr, 32'd0);
        chk("rst.d_exc", {31'd0, d_exception}, 32'd0);
        chk("rst.d_etval", d_etval, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // table: two 32-bit instructions, then a faulting word
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].fv, vecs[i].fa, vecs[i].fd, vecs[i].fe, vecs[i].dr);
            #1;
            chk($sformatf("vec%0d.d_valid", i), {31'd0, d_valid}, {31'd0, vecs[i].ev});
            chk($sformatf("vec%0d.f_ready", i), {31'd0, f_ready}, {31'd0, vecs[i].efr});
            chk($sformatf("vec%0d.d_pc", i), d_pc, vecs[i].epc);
            chk($sformatf("vec%0d.d_npc", i), d_npc, vecs[i].enpc);
            chk($sformatf("vec%0d.d_instr", i), d_instr, vecs[i].einstr);
            chk($sformatf("vec%0d.d_exc", i), {31'd0, d_exception}, {31'd0, vecs[i].eexc});
            chk($sformatf("vec%0d.d_etval", i), d_etval, vecs[i].eetv);
            @(negedge clk);
        end

        // fill to capacity with decode stalled, then drain in order
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h500 + 32'(4 * k), 32'h00000013 + 32'(k << 7), 1'b0, 1'b0);
            #1;
            chk($sformatf("fill%0d.f_ready", k), {31'd0, f_ready}, (k < 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        for (int j = 0; j < 4; j++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            #1;
            if (j == 0) chk("full.pop_no_ready", {31'd0, f_ready}, 32'd0);
            chk_instr($sformatf("drain%0d", j), 32'h500 + 32'(4 * j), 32'h504 + 32'(4 * j),
                      32'h00000013 + 32'(j << 7));
            @(negedge clk);
        end
        #1;
        chk("drain.empty", {31'd0, d_valid}, 32'd0);
        @(negedge clk);

        // flush discards queue and the push in the flush cycle
        drive(1'b1, 32'h700, 32'h00000013, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1; flush_pc = 32'h202;
        drive(1'b1, 32'h800, 32'h00000013, 1'b0, 1'b1);
        #1;
        chk("flush.d_valid", {31'd0, d_valid}, 32'd0);
        chk("flush.f_ready", {31'd0, f_ready}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 32'h200, 32'h45010013, 1'b0, 1'b1);
        #1;
        chk("post_flush.empty", {31'd0, d_valid}, 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
`ifdef INSTR_ALIGN_RVC_EN
        chk_instr("post_flush", 32'h202, 32'h204, 32'h00004501);
`else
        chk_instr("post_flush", 32'h200, 32'h204, 32'h45010013);
`endif
        @(negedge clk);
        #1;
        chk("post_flush.drained", {31'd0, d_valid}, 32'd0);
        @(negedge clk);

`ifdef INSTR_ALIGN_RVC_EN
        // mixed 16/32-bit stream with a word-straddling instruction
        drive(1'b1, 32'h100, 32'h00934505, 1'b0, 1'b1);
        #1;
        chk("rvc.first_empty", {31'd0, d_valid}, 32'd0);
        @(negedge clk);
        drive(1'b1, 32'h104, 32'h00000013, 1'b0, 1'b1);
        #1;
        chk_instr("rvc0", 32'h100, 32'h102, 32'h00004505);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1;
        chk_instr("rvc1", 32'h102, 32'h106, 32'h00130093);
        @(negedge clk);
        #1;
        chk_instr("rvc2", 32'h106, 32'h108, 32'h00000000);
        @(negedge clk);
        #1;
        chk("rvc.empty", {31'd0, d_valid}, 32'd0);
        @(negedge clk);

        // faulting lone 32-bit halfword issues without its partner
        flush = 1'b1; flush_pc = 32'h302;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b1, 32'h300, 32'hFFFF0000, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk_instr("exc1", 32'h302, 32'h306, d_instr);
        chk("exc1.d_exc", {31'd0, d_exception}, 32'd1);
        chk("exc1.d_etval", d_etval, 32'h302);
        chk("exc1.lo_half", {16'h0, d_instr[15:0]}, 32'h0000FFFF);
        @(negedge clk);
        d_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("exc1.popped", {31'd0, d_valid}, 32'd0);
        @(negedge clk);
`endif

        // reset mid-stream drops queued instructions immediately
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h600 + 32'(4 * k), 32'h00000013, 1'b0, 1'b0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pre_rst.d_valid", {31'd0, d_valid}, 32'd1);
        chk("pre_rst.f_ready", {31'd0, f_ready}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst.d_valid", {31'd0, d_valid}, 32'd0);
        chk("mid_rst.f_ready", {31'd0, f_ready}, 32'd1);
        chk("mid_rst.d_pc", d_pc, 32'd0);
        chk("mid_rst.d_instr", d_instr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        d_ready = 1'b1;
        #1;
        chk("post_rst.d_valid", {31'd0, d_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("post_rst.still_empty", {31'd0, d_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
